// File: rtl/led_flow_sched_if.sv
// led_flow_sched_if: groups the user-facing signals of the LED flow scheduler.
//   key_mode_n  - raw mode pushbutton, active-low, asynchronous to the clock
//   key_speed_n - raw speed pushbutton, active-low, asynchronous to the clock
//   en          - run enable; 0 freezes the display
//   led[3:0]    - LED drive, 1 = on (registered)
//   mode[1:0]   - current pattern mode (registered)
//   speed[1:0]  - current speed level, 0 = slowest (registered)
// master: the board/environment side.  slave: the scheduler.
interface led_flow_sched_if;
  logic       key_mode_n;
  logic       key_speed_n;
  logic       en;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;

  modport master (
    output key_mode_n,
    output key_speed_n,
    output en,
    input  led,
    input  mode,
    input  speed
  );

  modport slave (
    input  key_mode_n,
    input  key_speed_n,
    input  en,
    output led,
    output mode,
    output speed
  );
endinterface

// File: rtl/led_flow_sched.sv
// led_flow_sched: controller and scheduler for the 4-LED flow display.
// Synchronises and debounces the mode and speed pushbuttons, keeps the pattern
// mode (the FSM state) and speed level, runs the step-rate prescaler and
// sequences the LED register.
// Ports:
//   sys_clk50m - 50 MHz system clock
//   rst_n      - asynchronous active-low reset
//   bus        - led_flow_sched_if.slave (keys and en in; led, mode, speed out)
// Parameters:
//   TICK_DIV   - step period in clocks at speed 0; must be a multiple of 8
//   DEB_CNT    - debounce stability window in clocks
module led_flow_sched #(
  parameter int unsigned TICK_DIV = 12500000,
  parameter int unsigned DEB_CNT  = 1000000
) (
  input  logic             sys_clk50m,
  input  logic             rst_n,
  led_flow_sched_if.slave  bus
);

  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam int unsigned CntW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  localparam logic [CntW-1:0] DebLast  = CntW'(DEB_CNT - 1);
  // Last prescaler count for each speed level: period = TICK_DIV >> speed.
  localparam logic [PreW-1:0] PreLast0 = PreW'(TICK_DIV - 1);
  localparam logic [PreW-1:0] PreLast1 = PreW'((TICK_DIV >> 1) - 1);
  localparam logic [PreW-1:0] PreLast2 = PreW'((TICK_DIV >> 2) - 1);
  localparam logic [PreW-1:0] PreLast3 = PreW'((TICK_DIV >> 3) - 1);

  localparam int unsigned KeyMode  = 0;
  localparam int unsigned KeySpeed = 1;

  typedef enum logic [1:0] {
    StShiftL = 2'd0,
    StShiftR = 2'd1,
    StBounce = 2'd2,
    StBlink  = 2'd3
  } mode_e;

  function automatic logic [3:0] init_led(input mode_e m);
    unique case (m)
      StShiftL: init_led = 4'b0001;
      StShiftR: init_led = 4'b1000;
      StBounce: init_led = 4'b0001;
      StBlink:  init_led = 4'b1111;
      default:  init_led = 4'b0001;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Key path: 2-flop synchroniser, debounce counter, press pulse on 1->0.
  // ---------------------------------------------------------------------------
  logic [1:0]      raw_keys;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      stable_q, stable_d;
  logic [1:0]      press_q, press_d;
  logic [CntW-1:0] cnt_q [2];
  logic [CntW-1:0] cnt_d [2];

  assign raw_keys = {bus.key_speed_n, bus.key_mode_n};

  always_comb begin
    stable_d = stable_q;
    press_d  = '0;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == DebLast) begin
          stable_d[k] = ~stable_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
      press_d[k] = stable_q[k] & ~stable_d[k];
    end
  end

  always_ff @(posedge sys_clk50m or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      press_q  <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= raw_keys;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM, speed, prescaler and LED sequencing.
  // ---------------------------------------------------------------------------
  mode_e           mode_q, mode_d;
  logic [1:0]      speed_q, speed_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [PreW-1:0] pre_last;
  logic [3:0]      led_q, led_d;
  logic            dir_up_q, dir_up_d;
  logic            mode_press, speed_press, tick;

  assign mode_press  = press_q[KeyMode];
  assign speed_press = press_q[KeySpeed];

  always_comb begin
    mode_d   = mode_q;
    speed_d  = speed_q;
    pre_d    = pre_q;
    led_d    = led_q;
    dir_up_d = dir_up_q;

    unique case (speed_q)
      2'd0:    pre_last = PreLast0;
      2'd1:    pre_last = PreLast1;
      2'd2:    pre_last = PreLast2;
      default: pre_last = PreLast3;
    endcase
    tick = bus.en && (pre_q == pre_last);

    if (speed_press) begin
      speed_d = speed_q + 2'd1;
    end

    if (mode_press) begin
      unique case (mode_q)
        StShiftL: mode_d = StShiftR;
        StShiftR: mode_d = StBounce;
        StBounce: mode_d = StBlink;
        default:  mode_d = StShiftL;
      endcase
    end

    // Any press restarts the step period.
    if (mode_press || speed_press || tick) begin
      pre_d = '0;
    end else if (bus.en) begin
      pre_d = pre_q + 1'b1;
    end

    // A mode press takes priority over a tick landing in the same cycle.
    if (mode_press) begin
      led_d    = init_led(mode_d);
      dir_up_d = 1'b1;
    end else if (tick) begin
      unique case (mode_q)
        StShiftL: begin
          if (!$onehot(led_q))       led_d = 4'b0001;
          else                       led_d = {led_q[2:0], led_q[3]};
        end
        StShiftR: begin
          if (!$onehot(led_q))       led_d = 4'b1000;
          else                       led_d = {led_q[0], led_q[3:1]};
        end
        StBounce: begin
          if (!$onehot(led_q)) begin
            led_d    = 4'b0001;
            dir_up_d = 1'b1;
          end else if (dir_up_q) begin
            if (led_q == 4'b1000) begin
              led_d    = 4'b0100;
              dir_up_d = 1'b0;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q == 4'b0001) begin
              led_d    = 4'b0010;
              dir_up_d = 1'b1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        default: begin
          if (led_q == 4'b1111)      led_d = 4'b0000;
          else                       led_d = 4'b1111;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk50m or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= StShiftL;
      speed_q  <= 2'd0;
      pre_q    <= '0;
      led_q    <= 4'b0000;
      dir_up_q <= 1'b1;
    end else begin
      mode_q   <= mode_d;
      speed_q  <= speed_d;
      pre_q    <= pre_d;
      led_q    <= led_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign bus.led   = led_q;
  assign bus.mode  = mode_q;
  assign bus.speed = speed_q;

endmodule

// File: tb/tb_led_flow_sched.sv
// Directed bench for led_flow_sched with TICK_DIV=8, DEB_CNT=4.
// A key press reaches mode/speed 7 clocks after the raw falling edge
// (2 sync + 4 debounce + 1 pulse register).
module tb_led_flow_sched;
  logic sys_clk50m = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  led_flow_sched_if bus();

  led_flow_sched #(
    .TICK_DIV (8),
    .DEB_CNT  (4)
  ) dut (
    .sys_clk50m (sys_clk50m),
    .rst_n      (rst_n),
    .bus        (bus.slave)
  );

  always #5 sys_clk50m = ~sys_clk50m;

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk50m);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.key_mode_n = 1'b1;
    bus.key_speed_n = 1'b1;
    bus.en = 1'b1;
    cycles(3);
    checks++; if (bus.led !== 4'b0000) begin errors++; $display("FAIL reset_led: got %b want 0000", bus.led); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", bus.mode); end
    checks++; if (bus.speed !== 2'd0) begin errors++; $display("FAIL reset_speed: got %0d want 0", bus.speed); end
    rst_n = 1'b1;
    cycles(7);
    checks++; if (bus.led !== 4'b0000) begin errors++; $display("FAIL pre_first_tick: got %b want 0000", bus.led); end
    cycles(1);
    checks++; if (bus.led !== 4'b0001) begin errors++; $display("FAIL first_tick: got %b want 0001", bus.led); end
  endtask

  task automatic test_shift_left();
    logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      cycles(7);
      checks++; if (bus.led !== exp_seq[(i + 3) % 4] && i > 0) begin errors++; $display("FAIL shl_hold%0d: got %b want %b", i, bus.led, exp_seq[(i + 3) % 4]); end
      cycles(1);
      checks++; if (bus.led !== exp_seq[i]) begin errors++; $display("FAIL shl_step%0d: got %b want %b", i, bus.led, exp_seq[i]); end
    end
    checks++; if (bus.mode !== 2'd0 || bus.speed !== 2'd0) begin errors++; $display("FAIL shl_mode_speed: got %0d/%0d want 0/0", bus.mode, bus.speed); end
  endtask

  task automatic test_mode_press();
    bus.key_mode_n = 1'b0;
    cycles(6);
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL mode_latency: got %0d want 0", bus.mode); end
    cycles(1);
    checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL mode_step: got %0d want 1", bus.mode); end
    checks++; if (bus.led !== 4'b1000) begin errors++; $display("FAIL mode_init_led: got %b want 1000", bus.led); end
    cycles(8);
    checks++; if (bus.led !== 4'b0100) begin errors++; $display("FAIL shr_step: got %b want 0100", bus.led); end
    cycles(5);
    bus.key_mode_n = 1'b1;
    cycles(11);
    checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL mode_no_repeat: got %0d want 1", bus.mode); end
    checks++; if (bus.led !== 4'b0001) begin errors++; $display("FAIL shr_seq: got %b want 0001", bus.led); end
  endtask

  // en is held low while the press propagates, so the step count restarts
  // cleanly from the moment speed changes.
  task automatic test_speed_step(input logic [1:0] exp_speed, input int p,
                                 input logic [3:0] led0, input logic [3:0] led1,
                                 input logic [3:0] led2);
    bus.en = 1'b0;
    bus.key_speed_n = 1'b0;
    cycles(7);
    checks++; if (bus.speed !== exp_speed) begin errors++; $display("FAIL speed_val%0d: got %0d want %0d", exp_speed, bus.speed, exp_speed); end
    bus.en = 1'b1;
    cycles(p - 1);
    checks++; if (bus.led !== led0) begin errors++; $display("FAIL speed%0d_hold: got %b want %b", exp_speed, bus.led, led0); end
    cycles(1);
    checks++; if (bus.led !== led1) begin errors++; $display("FAIL speed%0d_tick1: got %b want %b", exp_speed, bus.led, led1); end
    cycles(p);
    checks++; if (bus.led !== led2) begin errors++; $display("FAIL speed%0d_tick2: got %b want %b", exp_speed, bus.led, led2); end
    bus.en = 1'b0;
    bus.key_speed_n = 1'b1;
    cycles(10);
  endtask

  task automatic test_speed();
    test_speed_step(2'd1, 4, 4'b0001, 4'b1000, 4'b0100);
    test_speed_step(2'd2, 2, 4'b0100, 4'b0010, 4'b0001);
    test_speed_step(2'd3, 1, 4'b0001, 4'b1000, 4'b0100);
    test_speed_step(2'd0, 8, 4'b0100, 4'b0010, 4'b0001);
  endtask

  task automatic test_bounce();
    logic [3:0] exp_seq [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                4'b0010, 4'b0001, 4'b0010, 4'b0100};
    bus.key_mode_n = 1'b0;
    cycles(7);
    checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL bounce_mode: got %0d want 2", bus.mode); end
    checks++; if (bus.led !== 4'b0001) begin errors++; $display("FAIL bounce_init: got %b want 0001", bus.led); end
    bus.en = 1'b1;
    cycles(1);
    bus.key_mode_n = 1'b1;
    cycles(7);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cycles(8);
      checks++; if (bus.led !== exp_seq[i]) begin errors++; $display("FAIL bounce_step%0d: got %b want %b", i, bus.led, exp_seq[i]); end
    end
  endtask

  task automatic test_glitch_and_collision();
    bus.key_mode_n = 1'b0;
    cycles(3);
    bus.key_mode_n = 1'b1;
    cycles(5);
    checks++; if (bus.led !== 4'b1000) begin errors++; $display("FAIL glitch_step1: got %b want 1000", bus.led); end
    cycles(8);
    checks++; if (bus.led !== 4'b0100) begin errors++; $display("FAIL glitch_step2: got %b want 0100", bus.led); end
    checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL glitch_mode: got %0d want 2", bus.mode); end
    // Start the press so its pulse coincides with the next tick.
    cycles(1);
    bus.key_mode_n = 1'b0;
    cycles(6);
    checks++; if (bus.mode !== 2'd2 || bus.led !== 4'b0100) begin errors++; $display("FAIL collide_before: got %0d/%b want 2/0100", bus.mode, bus.led); end
    cycles(1);
    checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL collide_mode: got %0d want 3", bus.mode); end
    checks++; if (bus.led !== 4'b1111) begin errors++; $display("FAIL collide_led: got %b want 1111", bus.led); end
    cycles(1);
    bus.key_mode_n = 1'b1;
    cycles(7);
    checks++; if (bus.led !== 4'b0000) begin errors++; $display("FAIL blink_off: got %b want 0000", bus.led); end
    cycles(8);
    checks++; if (bus.led !== 4'b1111) begin errors++; $display("FAIL blink_on: got %b want 1111", bus.led); end
  endtask

  task automatic test_enable_hold();
    cycles(3);
    bus.en = 1'b0;
    cycles(30);
    checks++; if (bus.led !== 4'b1111) begin errors++; $display("FAIL en_frozen: got %b want 1111", bus.led); end
    bus.en = 1'b1;
    cycles(4);
    checks++; if (bus.led !== 4'b1111) begin errors++; $display("FAIL en_resume_hold: got %b want 1111", bus.led); end
    cycles(1);
    checks++; if (bus.led !== 4'b0000) begin errors++; $display("FAIL en_resume_tick: got %b want 0000", bus.led); end
  endtask

  task automatic test_async_reset();
    cycles(8);
    checks++; if (bus.led !== 4'b1111 || bus.mode !== 2'd3) begin errors++; $display("FAIL pre_reset_state: got %b/%0d want 1111/3", bus.led, bus.mode); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.led !== 4'b0000) begin errors++; $display("FAIL async_led: got %b want 0000", bus.led); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL async_mode: got %0d want 0", bus.mode); end
    checks++; if (bus.speed !== 2'd0) begin errors++; $display("FAIL async_speed: got %0d want 0", bus.speed); end
    cycles(2);
    rst_n = 1'b1;
    cycles(7);
    checks++; if (bus.led !== 4'b0000) begin errors++; $display("FAIL rerun_hold: got %b want 0000", bus.led); end
    cycles(1);
    checks++; if (bus.led !== 4'b0001) begin errors++; $display("FAIL rerun_tick: got %b want 0001", bus.led); end
  endtask

  initial begin
    test_reset();
    test_shift_left();
    test_mode_press();
    test_speed();
    test_bounce();
    test_glitch_and_collision();
    test_enable_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
